// File: rtl/pwm_width_monitor.sv
// PWM high-pulse width monitor: measures each synchronized pulse in clk cycles
// and flags width deviations and stuck-high timeouts.
module pwm_width_monitor #(
    parameter int WIDTH_BITS  = 13,
    parameter int TOL         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  signal_in,
    input  logic [WIDTH_BITS-1:0] W,
    output logic [WIDTH_BITS-1:0] meas,
    output logic                  meas_valid,
    output logic                  width_err,
    output logic                  timeout_err,
    output logic [ERR_BITS-1:0]   err_count
);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, WAIT_LOW} state_t;

    localparam logic [WIDTH_BITS-1:0] CNT_MAX = '1;
    localparam logic [ERR_BITS-1:0]   ERR_MAX = '1;
    localparam logic [WIDTH_BITS:0]   TOL_V   = (WIDTH_BITS+1)'(TOL);

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [SYNC_STAGES-1:0]  vld_q, vld_d;
    logic                    s_d_q, s_d_d;
    logic [WIDTH_BITS-1:0]   cnt_q, cnt_d;
    logic [WIDTH_BITS-1:0]   w_lat_q, w_lat_d;
    logic [WIDTH_BITS-1:0]   meas_q, meas_d;
    logic                    mv_q, mv_d;
    logic                    we_q, we_d;
    logic                    te_q, te_d;
    logic [ERR_BITS-1:0]     err_q, err_d;

    logic                    s_sync, rise, fall, primed;
    logic signed [WIDTH_BITS:0] diff;
    logic [WIDTH_BITS:0]     mag;

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_d_q;
    assign fall   = ~s_sync & s_d_q;
    // s_sync is only trusted once the chain has refilled since reset
    assign primed = vld_q[SYNC_STAGES-1];

    assign diff = $signed({1'b0, cnt_q}) - $signed({1'b0, w_lat_q});
    assign mag  = diff[WIDTH_BITS] ? -diff : diff;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], signal_in};
        vld_d  = {vld_q[SYNC_STAGES-2:0], 1'b1};
        s_d_d  = s_sync;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= '0;
            vld_q   <= '0;
            s_d_q   <= 1'b0;
            cnt_q   <= '0;
            w_lat_q <= '0;
            meas_q  <= '0;
            mv_q    <= 1'b0;
            we_q    <= 1'b0;
            te_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            s_d_q   <= s_d_d;
            cnt_q   <= cnt_d;
            w_lat_q <= w_lat_d;
            meas_q  <= meas_d;
            mv_q    <= mv_d;
            we_q    <= we_d;
            te_q    <= te_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:     if (primed && !s_sync) state_d = ARMED;
                ARMED:    if (rise) state_d = MEASURE;
                MEASURE: begin
                    if (fall) state_d = ARMED;
                    else if (s_sync && cnt_q == CNT_MAX) state_d = WAIT_LOW;
                end
                WAIT_LOW: if (!s_sync) state_d = ARMED;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        w_lat_d = w_lat_q;
        meas_d  = meas_q;
        mv_d    = 1'b0;
        we_d    = 1'b0;
        te_d    = 1'b0;
        err_d   = err_q;
        if (!en) begin
            cnt_d = '0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (rise) begin
                        cnt_d   = 1;
                        w_lat_d = W;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        meas_d = cnt_q;
                        mv_d   = 1'b1;
                        we_d   = mag > TOL_V;
                    end else if (s_sync) begin
                        if (cnt_q == CNT_MAX) begin
                            meas_d = CNT_MAX;
                            te_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        if ((we_d || te_d) && err_q != ERR_MAX)
            err_d = err_q + 1'b1;
    end

    assign meas        = meas_q;
    assign meas_valid  = mv_q;
    assign width_err   = we_q;
    assign timeout_err = te_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_pwm_width_monitor.sv
// Directed bench for pwm_width_monitor: pulse widths, tolerance edge,
// partial pulses, enable drop, timeout, reset abort and counter saturation.
module tb_pwm_width_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        signal_in;
    logic [12:0] W;
    logic [12:0] meas;
    logic        meas_valid;
    logic        width_err;
    logic        timeout_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_mv = 0;
    int n_to = 0;
    int base_mv;
    int base_to;
    logic [12:0] last_meas = '0;
    logic        last_we = 1'b0;

    pwm_width_monitor dut (
        .clk(clk), .reset(reset), .en(en), .signal_in(signal_in), .W(W),
        .meas(meas), .meas_valid(meas_valid), .width_err(width_err),
        .timeout_err(timeout_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (meas_valid) begin
            n_mv++;
            last_meas = meas;
            last_we = width_err;
        end
        if (timeout_err) n_to++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int n, input int gap);
        @(negedge clk);
        signal_in = 1'b1;
        cyc(n);
        signal_in = 1'b0;
        cyc(gap);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; signal_in = 1'b0; W = '0;
        cyc(3);
        chk("rst_meas", int'(meas), 0);
        chk("rst_mv", int'(meas_valid), 0);
        chk("rst_we", int'(width_err), 0);
        chk("rst_te", int'(timeout_err), 0);
        chk("rst_err", int'(err_count), 0);
        reset = 1'b0; en = 1'b1; W = 13'd100;
        cyc(5);

        base_mv = n_mv;
        pulse(100, 8);
        chk("p100_cnt", n_mv - base_mv, 1);
        chk("p100_meas", int'(last_meas), 100);
        chk("p100_we", int'(last_we), 0);
        chk("p100_err", int'(err_count), 0);

        pulse(102, 8);
        chk("p102_meas", int'(last_meas), 102);
        chk("p102_we", int'(last_we), 0);
        pulse(103, 8);
        chk("p103_cnt", n_mv - base_mv, 3);
        chk("p103_meas", int'(meas), 103);
        chk("p103_we", int'(last_we), 1);
        chk("p103_err", int'(err_count), 1);

        base_mv = n_mv;
        @(negedge clk);
        signal_in = 1'b1;
        cyc(40);
        reset = 1'b1;
        #1;
        chk("abort_meas", int'(meas), 0);
        chk("abort_err", int'(err_count), 0);
        chk("abort_mv", int'(meas_valid), 0);
        cyc(2);
        reset = 1'b0;
        cyc(58);
        signal_in = 1'b0;
        cyc(8);
        chk("abort_nostrobe", n_mv - base_mv, 0);
        pulse(100, 8);
        chk("abort_next", int'(last_meas), 100);
        chk("abort_next_cnt", n_mv - base_mv, 1);

        reset = 1'b1;
        signal_in = 1'b1;
        cyc(2);
        reset = 1'b0;
        base_mv = n_mv;
        cyc(50);
        signal_in = 1'b0;
        W = 13'd20;
        cyc(8);
        pulse(20, 8);
        chk("partial_cnt", n_mv - base_mv, 1);
        chk("partial_meas", int'(last_meas), 20);
        chk("partial_we", int'(last_we), 0);

        W = 13'd7;
        base_mv = n_mv;
        @(negedge clk);
        signal_in = 1'b1;
        cyc(10);
        en = 1'b0;
        cyc(20);
        signal_in = 1'b0;
        cyc(4);
        en = 1'b1;
        cyc(5);
        chk("en_drop_cnt", n_mv - base_mv, 0);
        chk("en_drop_hold", int'(meas), 20);
        pulse(7, 8);
        chk("en_next_meas", int'(last_meas), 7);
        W = 13'd1;
        pulse(1, 8);
        chk("min_meas", int'(last_meas), 1);
        chk("min_we", int'(last_we), 0);
        chk("min_err", int'(err_count), 0);

        W = 13'd6479;
        base_mv = n_mv;
        base_to = n_to;
        @(negedge clk);
        signal_in = 1'b1;
        cyc(8300);
        chk("to_cnt", n_to - base_to, 1);
        chk("to_nomv", n_mv - base_mv, 0);
        chk("to_meas", int'(meas), 8191);
        chk("to_err", int'(err_count), 1);
        signal_in = 1'b0;
        cyc(8);
        pulse(10, 8);
        chk("to_next_meas", int'(last_meas), 10);
        chk("to_next_we", int'(last_we), 1);
        chk("to_next_err", int'(err_count), 2);

        W = 13'd50;
        base_mv = n_mv;
        for (int i = 0; i < 300; i++) pulse(5, 1);
        cyc(8);
        chk("sat_cnt", n_mv - base_mv, 300);
        chk("sat_meas", int'(meas), 5);
        chk("sat_err", int'(err_count), 255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
